hazard_ctrl: RTL and testbench

//   Parametrised hazard/stall controller for the 5-stage pipeline, the successor
//   to the combinational hazard unit. Adds a load-use FSM that holds the pipe

---
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use FSM covering dcache
// misses and bubble insertion, deferred branch/jump flushes, saturating perf counters.
module hazard_ctrl #(
    parameter int REG_W      = 5,
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_jump,
    input  logic             ex_branch,
    input  logic             ex_mispredict,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             mem_load,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             dhit,
    input  logic             perf_clr,
    output logic             stall,
    output logic             id_flush,
    output logic             ex_flush,
    output logic             mem_flush,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MISS   = 2'd1,
        BUBBLE = 2'd2
    } state_t;

    localparam bit         HAS_BUB   = (LU_BUBBLES > 0);
    localparam bit         MULTI_BUB = (LU_BUBBLES > 1);
    localparam logic [2:0] BUB_INIT  = HAS_BUB ? 3'(LU_BUBBLES - 1) : 3'd0;

    state_t     state, state_nxt;
    logic [2:0] bub, bub_nxt;
    logic       haz;
    logic       br_flush;
    logic       stall_raw;
    logic       mem_flush_raw;
    logic       any_flush;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

    // $zero never carries a real dependency, so a load to r0 is ignored.
    assign haz = mem_load && (mem_rd != '0) && ((mem_rd == ex_rs) || (mem_rd == ex_rt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            bub   <= 3'd0;
        end else begin
            state <= state_nxt;
            bub   <= bub_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bub_nxt       = bub;
        stall_raw     = 1'b0;
        mem_flush_raw = 1'b0;
        case (state)
            RUN: begin
                if (haz) begin
                    if (!dhit) begin
                        stall_raw = 1'b1;
                        state_nxt = MISS;
                    end else if (HAS_BUB) begin
                        stall_raw     = 1'b1;
                        mem_flush_raw = 1'b1;
                        bub_nxt       = BUB_INIT;
                        state_nxt     = MULTI_BUB ? BUBBLE : RUN;
                    end
                end
            end
            MISS: begin
                stall_raw = 1'b1;
                if (dhit) begin
                    state_nxt = RUN;
                    if (HAS_BUB) begin
                        mem_flush_raw = 1'b1;
                        bub_nxt       = BUB_INIT;
                        if (MULTI_BUB) state_nxt = BUBBLE;
                    end else begin
                        stall_raw = 1'b0;
                    end
                end
            end
            BUBBLE: begin
                // bub counts bubbles still owed including this one.
                stall_raw     = 1'b1;
                mem_flush_raw = 1'b1;
                if (bub <= 3'd1) begin
                    bub_nxt   = 3'd0;
                    state_nxt = RUN;
                end else begin
                    bub_nxt = bub - 3'd1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Frozen EX/ID re-present a pending branch/jump, so flushes simply wait for stall=0.
    always_comb begin
        br_flush  = ex_branch && ex_mispredict;
        stall     = stall_raw && !rst;
        mem_flush = mem_flush_raw && !rst;
        id_flush  = !stall_raw && !rst && (id_jump || br_flush);
        ex_flush  = !stall_raw && !rst && br_flush;
        busy      = (state != RUN);
        any_flush = id_flush || ex_flush || mem_flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (perf_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= sat_inc(stall_cnt, stall);
            flush_cnt <= sat_inc(flush_cnt, any_flush);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (LU_BUBBLES 1/2/0, CNT_W 16/4/16)
// driven in parallel and compared against a per-instance behavioural model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_jump, ex_branch, ex_mispredict, mem_load, dhit, perf_clr;
    logic [4:0] ex_rs, ex_rt, mem_rd;

    logic        st_a, idf_a, exf_a, mf_a, bz_a;
    logic        st_b, idf_b, exf_b, mf_b, bz_b;
    logic        st_c, idf_c, exf_c, mf_c, bz_c;
    logic [15:0] sc_a, fc_a, sc_c, fc_c;
    logic [3:0]  sc_b, fc_b;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state per instance: waiting for dhit, bubbles still owed, counters.
    int lu    [3] = '{1, 2, 0};
    int cw    [3] = '{16, 4, 16};
    bit pend  [3];
    int bleft [3];
    int scnt  [3];
    int fcnt  [3];

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(5), .LU_BUBBLES(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .id_jump(id_jump), .ex_branch(ex_branch),
        .ex_mispredict(ex_mispredict), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .mem_load(mem_load), .mem_rd(mem_rd), .dhit(dhit), .perf_clr(perf_clr),
        .stall(st_a), .id_flush(idf_a), .ex_flush(exf_a), .mem_flush(mf_a),
        .busy(bz_a), .stall_cnt(sc_a), .flush_cnt(fc_a));

    hazard_ctrl #(.REG_W(5), .LU_BUBBLES(2), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .id_jump(id_jump), .ex_branch(ex_branch),
        .ex_mispredict(ex_mispredict), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .mem_load(mem_load), .mem_rd(mem_rd), .dhit(dhit), .perf_clr(perf_clr),
        .stall(st_b), .id_flush(idf_b), .ex_flush(exf_b), .mem_flush(mf_b),
        .busy(bz_b), .stall_cnt(sc_b), .flush_cnt(fc_b));

    hazard_ctrl #(.REG_W(5), .LU_BUBBLES(0), .CNT_W(16)) u_c (
        .clk(clk), .rst(rst), .id_jump(id_jump), .ex_branch(ex_branch),
        .ex_mispredict(ex_mispredict), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .mem_load(mem_load), .mem_rd(mem_rd), .dhit(dhit), .perf_clr(perf_clr),
        .stall(st_c), .id_flush(idf_c), .ex_flush(exf_c), .mem_flush(mf_c),
        .busy(bz_c), .stall_cnt(sc_c), .flush_cnt(fc_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            pend[i] = 1'b0; bleft[i] = 0; scnt[i] = 0; fcnt[i] = 0;
        end
    endtask

    // One clock: compare outputs mid-cycle, then advance the model across the edge.
    task automatic step();
        logic [31:0] o_st [3], o_idf [3], o_exf [3], o_mf [3], o_bz [3], o_sc [3], o_fc [3];
        bit haz, e_st, e_mf, e_br, e_idf, e_exf, e_bz, np;
        int nb, maxc;
        @(negedge clk);
        o_st  = '{32'(st_a),  32'(st_b),  32'(st_c)};
        o_idf = '{32'(idf_a), 32'(idf_b), 32'(idf_c)};
        o_exf = '{32'(exf_a), 32'(exf_b), 32'(exf_c)};
        o_mf  = '{32'(mf_a),  32'(mf_b),  32'(mf_c)};
        o_bz  = '{32'(bz_a),  32'(bz_b),  32'(bz_c)};
        o_sc  = '{32'(sc_a),  32'(sc_b),  32'(sc_c)};
        o_fc  = '{32'(fc_a),  32'(fc_b),  32'(fc_c)};
        haz = mem_load && (mem_rd != 0) && (mem_rd == ex_rs || mem_rd == ex_rt);
        for (int i = 0; i < 3; i++) begin
            e_st = 0; e_mf = 0; np = pend[i]; nb = bleft[i];
            if (bleft[i] > 0) begin
                e_st = 1; e_mf = 1; nb = bleft[i] - 1;
            end else if (pend[i] || haz) begin
                if (!dhit) begin
                    e_st = 1; np = 1;
                end else begin
                    np = 0;
                    if (lu[i] > 0) begin
                        e_st = 1; e_mf = 1; nb = lu[i] - 1;
                    end
                end
            end
            e_br  = ex_branch && ex_mispredict;
            e_idf = !e_st && (id_jump || e_br);
            e_exf = !e_st && e_br;
            e_bz  = pend[i] || (bleft[i] > 0);
            chk($sformatf("stall[%0d]", i), o_st[i], 32'(e_st));
            chk($sformatf("id_flush[%0d]", i), o_idf[i], 32'(e_idf));
            chk($sformatf("ex_flush[%0d]", i), o_exf[i], 32'(e_exf));
            chk($sformatf("mem_flush[%0d]", i), o_mf[i], 32'(e_mf));
            chk($sformatf("busy[%0d]", i), o_bz[i], 32'(e_bz));
            chk($sformatf("stall_cnt[%0d]", i), o_sc[i], 32'(scnt[i]));
            chk($sformatf("flush_cnt[%0d]", i), o_fc[i], 32'(fcnt[i]));
            maxc = (1 << cw[i]) - 1;
            if (perf_clr) begin
                scnt[i] = 0; fcnt[i] = 0;
            end else begin
                if (e_st && scnt[i] < maxc) scnt[i]++;
                if ((e_idf || e_exf || e_mf) && fcnt[i] < maxc) fcnt[i]++;
            end
            pend[i] = np; bleft[i] = nb;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; id_jump = 0; ex_branch = 0; ex_mispredict = 0; mem_load = 0;
        dhit = 0; perf_clr = 0; ex_rs = 0; ex_rt = 0; mem_rd = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_busy", 32'(bz_b), 0);
        chk("reset_stall", 32'(st_a), 0);
        chk("reset_scnt", 32'(sc_a), 0);
        chk("reset_fcnt", 32'(fc_b), 0);

        // Load-use hit with one bubble
        mem_load = 1; mem_rd = 5; ex_rs = 5; dhit = 1;
        step();
        mem_load = 0; dhit = 0;
        step(); step();
        chk("t1_scnt_a", 32'(sc_a), 1);
        chk("t1_fcnt_a", 32'(fc_a), 1);
        perf_clr = 1; step(); perf_clr = 0;

        // Four-cycle miss then hit, two bubbles on instance b
        mem_load = 1; mem_rd = 5; ex_rs = 5;
        repeat (4) step();
        dhit = 1; step();
        mem_load = 0; dhit = 0;
        repeat (3) step();
        chk("t2_scnt_b", 32'(sc_b), 6);
        chk("t2_fcnt_b", 32'(fc_b), 2);
        chk("t2_scnt_a", 32'(sc_a), 5);

        // Zero-register exclusion
        mem_load = 1; mem_rd = 0; ex_rs = 0; ex_rt = 0;
        step(); step();
        chk("t3_nostall", 32'(st_a), 0);
        mem_load = 0;

        // Mispredict held during a miss
        mem_load = 1; mem_rd = 7; ex_rt = 7; ex_branch = 1; ex_mispredict = 1;
        repeat (3) step();
        dhit = 1; step();
        mem_load = 0; dhit = 0;
        step(); step();
        ex_branch = 0; ex_mispredict = 0; ex_rt = 0;
        step();

        // Counter saturation with CNT_W=4, then clear while stalled
        perf_clr = 1; step(); perf_clr = 0;
        mem_load = 1; mem_rd = 3; ex_rs = 3;
        repeat (20) step();
        chk("t6_sat_b", 32'(sc_b), 15);
        chk("t6_busy_b", 32'(bz_b), 1);
        perf_clr = 1; step(); perf_clr = 0;
        chk("t6_clr_b", 32'(sc_b), 0);
        dhit = 1; step();
        mem_load = 0; dhit = 0;
        repeat (3) step();

        // Asynchronous reset while instance b is in BUBBLE
        mem_load = 1; mem_rd = 3; ex_rs = 3; dhit = 1;
        step();
        chk("t5_pre_busy_b", 32'(bz_b), 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_stall_b", 32'(st_b), 0);
        chk("t5_mflush_b", 32'(mf_b), 0);
        chk("t5_busy_b", 32'(bz_b), 0);
        chk("t5_scnt_b", 32'(sc_b), 0);
        chk("t5_stall_a", 32'(st_a), 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0; mem_load = 0; dhit = 0;

        // Randomized traffic
        repeat (600) begin
            mem_load      = ($urandom_range(0, 1) == 1);
            mem_rd        = 5'($urandom_range(0, 3));
            ex_rs         = 5'($urandom_range(0, 3));
            ex_rt         = 5'($urandom_range(0, 3));
            dhit          = ($urandom_range(0, 2) == 0);
            ex_branch     = ($urandom_range(0, 3) == 0);
            ex_mispredict = ex_branch && ($urandom_range(0, 1) == 1);
            id_jump       = ($urandom_range(0, 5) == 0);
            perf_clr      = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
